// File: rtl/xy_result_fifo_if.sv
// ---------------------------------------------------------------------------
// xy_result_fifo_if
// Bundles the producer handshake, the consumer handshake and the status /
// statistics outputs of xy_result_fifo into one interface.
//   in_valid, x, y      : X/Y pair offered by the pipeline
//   out_ready           : consumer accepts the head entry
//   out_valid, out_x/y  : head entry presented to the consumer
//   level, full, empty  : occupancy status
//   overflow            : sticky "a pair was dropped" flag
//   cnt_x, cnt_y        : saturating tallies of accepted x=1 / y=1 pairs
// Modports: slave is the FIFO's view, master is the surrounding logic's view.
// ---------------------------------------------------------------------------
interface xy_result_fifo_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  logic                         in_valid;
  logic                         x;
  logic                         y;
  logic                         out_ready;
  logic                         out_valid;
  logic                         out_x;
  logic                         out_y;
  logic [$clog2(DEPTH+1)-1:0]   level;
  logic                         full;
  logic                         empty;
  logic                         overflow;
  logic [CNT_W-1:0]             cnt_x;
  logic [CNT_W-1:0]             cnt_y;

  modport slave (
    input  in_valid, x, y, out_ready,
    output out_valid, out_x, out_y, level, full, empty, overflow, cnt_x, cnt_y
  );

  modport master (
    output in_valid, x, y, out_ready,
    input  out_valid, out_x, out_y, level, full, empty, overflow, cnt_x, cnt_y
  );
endinterface

// File: rtl/xy_result_fifo.sv
// ---------------------------------------------------------------------------
// xy_result_fifo
// Captures the X/Y result pair produced by the pipeline each clock, buffers it
// in a small first-word-fall-through FIFO and hands it to a consumer over a
// valid/ready handshake. A pair offered while the FIFO is full and not being
// popped is dropped and latches the sticky overflow flag.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : synchronous, active-low reset
//   bus      : xy_result_fifo_if.slave (handshakes, status, statistics)
// Optional feature macro: XY_SINK_STATS_EN
//   defined   -> cnt_x/cnt_y count accepted pairs with x=1 / y=1, saturating
//   undefined -> cnt_x/cnt_y are tied to zero, no counter logic
// ---------------------------------------------------------------------------
module xy_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  xy_result_fifo_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, pop, push, drop;
  logic [1:0]       head;

  // Status comes only from the occupancy register, so full/empty/level have
  // no combinational path from in_valid or out_ready.
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  // A full FIFO still accepts a pair when the head leaves in the same cycle.
  assign pop  = !empty && bus.out_ready;
  assign push = bus.in_valid && (!full || pop);
  assign drop = bus.in_valid && full && !pop;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;
    if (push) wrPtr_d = wrPtr_q + 1'b1;
    if (pop)  rdPtr_d = rdPtr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: stale entries are never visible because the
  // occupancy counter gates out_valid and the output data.
  always_ff @(posedge clk) begin
    if (reset_n && push) mem_q[wrPtr_q] <= {bus.x, bus.y};
  end

  assign head          = mem_q[rdPtr_q];
  assign bus.out_valid = !empty;
  assign bus.out_x     = !empty && head[1];
  assign bus.out_y     = !empty && head[0];
  assign bus.level     = level_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;

`ifdef XY_SINK_STATS_EN
  logic [CNT_W-1:0] cntX_q, cntX_d;
  logic [CNT_W-1:0] cntY_q, cntY_d;

  // Only accepted pairs are counted; each counter sticks at all-ones.
  always_comb begin
    cntX_d = cntX_q;
    cntY_d = cntY_q;
    if (push && bus.x && (cntX_q != '1)) cntX_d = cntX_q + 1'b1;
    if (push && bus.y && (cntY_q != '1)) cntY_d = cntY_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cntX_q <= '0;
      cntY_q <= '0;
    end else begin
      cntX_q <= cntX_d;
      cntY_q <= cntY_d;
    end
  end

  assign bus.cnt_x = cntX_q;
  assign bus.cnt_y = cntY_q;
`else
  assign bus.cnt_x = '0;
  assign bus.cnt_y = '0;
`endif
endmodule

// File: tb/tb_xy_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_xy_result_fifo
// Drives xy_result_fifo (DEPTH=4, CNT_W=2) through directed steps followed by
// a randomized stretch, comparing every cycle against a queue-based model of
// the FIFO behaviour.
// ---------------------------------------------------------------------------
module tb_xy_result_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  logic [1:0] modelQ [$];
  bit         modelOvf;
  int         modelCx;
  int         modelCy;

  xy_result_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  xy_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted, and reported with tag/observed/expected on failure.
  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Compare every DUT output against the model's current state.
  task automatic checkOutput(input string tag);
    int         n;
    logic [1:0] head;
    int         expCx;
    int         expCy;
    n    = modelQ.size();
    head = (n != 0) ? modelQ[0] : 2'b00;
`ifdef XY_SINK_STATS_EN
    expCx = modelCx;
    expCy = modelCy;
`else
    expCx = 0;
    expCy = 0;
`endif
    chk({tag, ".out_valid"}, int'(bus.out_valid), int'(n != 0));
    chk({tag, ".out_x"},     int'(bus.out_x),     int'(head[1]));
    chk({tag, ".out_y"},     int'(bus.out_y),     int'(head[0]));
    chk({tag, ".level"},     int'(bus.level),     n);
    chk({tag, ".full"},      int'(bus.full),      int'(n == DEPTH));
    chk({tag, ".empty"},     int'(bus.empty),     int'(n == 0));
    chk({tag, ".overflow"},  int'(bus.overflow),  int'(modelOvf));
    chk({tag, ".cnt_x"},     int'(bus.cnt_x),     expCx);
    chk({tag, ".cnt_y"},     int'(bus.cnt_y),     expCy);
  endtask

  // Drive one cycle of inputs, advance the model, clock, then check #1 later.
  task automatic applyStimulus(input string tag, input logic rstN, input logic v,
                               input logic xi, input logic yi, input logic rdy);
    bit popNow;
    bit pushNow;
    reset_n       = rstN;
    bus.in_valid  = v;
    bus.x         = xi;
    bus.y         = yi;
    bus.out_ready = rdy;
    if (!rstN) begin
      modelQ.delete();
      modelOvf = 1'b0;
      modelCx  = 0;
      modelCy  = 0;
    end else begin
      popNow  = (modelQ.size() != 0) && rdy;
      pushNow = v && ((modelQ.size() < DEPTH) || popNow);
      if (popNow) void'(modelQ.pop_front());
      if (pushNow) begin
        modelQ.push_back({xi, yi});
        if (xi && modelCx < MAXC) modelCx++;
        if (yi && modelCy < MAXC) modelCy++;
      end else if (v) begin
        modelOvf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = 1'b0;
    bus.y = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted.
    applyStimulus("rst0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("rst1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst.empty_const", int'(bus.empty), 1);

    // Single pass: pair appears next cycle, then drains.
    applyStimulus("single_push", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("single.out_x_const", int'(bus.out_x), 1);
    applyStimulus("single_pop", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("single.empty_const", int'(bus.empty), 1);

    // Fill, then push into full FIFO while popping.
    applyStimulus("fill0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("fill1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("fill2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus("fill3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fill.level_const", int'(bus.level), 4);
    applyStimulus("fullpop", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("fullpop.ovf_const", int'(bus.overflow), 0);
    for (int i = 0; i < 4; i++) applyStimulus("fullpop_drain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Fill, overflow on fifth push, drain in order.
    applyStimulus("refill0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("refill1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("refill2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus("refill3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("drop", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("drop.ovf_const", int'(bus.overflow), 1);
    for (int i = 0; i < 5; i++) applyStimulus("drain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-stream at level 3.
    for (int i = 0; i < 3; i++) applyStimulus("pre_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("mid_rst", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("mid_rst.level_const", int'(bus.level), 0);
    applyStimulus("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Statistics: five x=1 pairs while draining.
    for (int i = 0; i < 5; i++) applyStimulus("stats", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef XY_SINK_STATS_EN
    chk("stats.cnt_x_sat", int'(bus.cnt_x), 3);
`else
    chk("stats.cnt_x_off", int'(bus.cnt_x), 0);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(63) != 0), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 1'($urandom_range(1)),
                    ($urandom_range(3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
